// File: rtl/snake_core.sv
// snake_core: grid snake engine with a shift-buffer body, LFSR food placement and a
// registered cell-query port for a renderer. Define SNAKE_WRAP_EN to wrap the head at grid edges.
module snake_core #(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 12,
    parameter int MAX_LEN  = 16,
    parameter int STEP_DIV = 6250000,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    input  logic          start,
    input  logic [XW-1:0] query_x,
    input  logic [YW-1:0] query_y,
    output logic          hit_head,
    output logic          hit_body,
    output logic          hit_food,
    output logic [LW-1:0] length,
    output logic          running,
    output logic          game_over,
    output logic          step_o
);
    localparam int CW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STEP_DIV - 1);
    localparam logic [XW-1:0] HOME_X    = XW'(GRID_W / 2);
    localparam logic [YW-1:0] HOME_Y    = YW'(GRID_H / 2);
    localparam logic [XW-1:0] FOOD_X0   = XW'(GRID_W - 2);
    localparam logic [XW:0]   X_OVER    = (XW+1)'(GRID_W);
    localparam logic [YW:0]   Y_OVER    = (YW+1)'(GRID_H);
    localparam logic [15:0]   LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FOOD, S_OVER} state_t;
    // Opposite directions differ only in bit 0, which makes the reverse test a single XOR.
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    state_t        state;
    dir_t          dir, pend, btn_dir, ref_dir, next_pend;
    logic          btn_any, do_step, wall_hit, self_hit, eat, grow;
    logic          cand_ok, on_body, q_head, q_body, q_food;
    logic [XW-1:0] body_x [MAX_LEN];
    logic [YW-1:0] body_y [MAX_LEN];
    logic [XW-1:0] food_x, nx, cand_x;
    logic [YW-1:0] food_y, ny, cand_y;
    logic [XW:0]   mv_x;
    logic [YW:0]   mv_y;
    logic [LW-1:0] len_q;
    logic [15:0]   lfsr, lfsr_next;
    logic [CW-1:0] cnt;

    function automatic logic [XW-1:0] init_x(input int i);
        if (i == 0) return HOME_X;
        if (i == 1) return HOME_X - XW'(1);
        return HOME_X - XW'(2);
    endfunction

    assign length    = len_q;
    assign running   = (state == S_RUN) || (state == S_FOOD);
    assign game_over = (state == S_OVER);
    assign do_step   = (state == S_RUN) && (cnt == CNT_LAST);
    // On a step edge the pending direction becomes committed, so reverse-check against it.
    assign ref_dir   = do_step ? pend : dir;
    assign next_pend = (btn_any && (btn_dir != dir_t'(ref_dir ^ 2'b01))) ? btn_dir : pend;
    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign cand_x    = lfsr[XW-1:0];
    assign cand_y    = lfsr[XW+YW-1:XW];
    assign eat       = (nx == food_x) && (ny == food_y);
    assign grow      = eat && (len_q != LW'(MAX_LEN));

    always_comb begin
        btn_any = 1'b1;
        btn_dir = D_RIGHT;
        if (up)         btn_dir = D_UP;
        else if (down)  btn_dir = D_DOWN;
        else if (left)  btn_dir = D_LEFT;
        else if (right) btn_dir = D_RIGHT;
        else            btn_any = 1'b0;
    end

    // One extra bit keeps -1 and GRID_W distinguishable from in-range coordinates.
    always_comb begin
        mv_x = {1'b0, body_x[0]};
        mv_y = {1'b0, body_y[0]};
        case (pend)
            D_UP:    mv_y = mv_y - (YW+1)'(1);
            D_DOWN:  mv_y = mv_y + (YW+1)'(1);
            D_LEFT:  mv_x = mv_x - (XW+1)'(1);
            D_RIGHT: mv_x = mv_x + (XW+1)'(1);
        endcase
`ifdef SNAKE_WRAP_EN
        wall_hit = 1'b0;
        if (mv_x == '1)          nx = XW'(GRID_W - 1);
        else if (mv_x == X_OVER) nx = '0;
        else                     nx = mv_x[XW-1:0];
        if (mv_y == '1)          ny = YW'(GRID_H - 1);
        else if (mv_y == Y_OVER) ny = '0;
        else                     ny = mv_y[YW-1:0];
`else
        wall_hit = (mv_x >= X_OVER) || (mv_y >= Y_OVER);
        nx = mv_x[XW-1:0];
        ny = mv_y[YW-1:0];
`endif
    end

    always_comb begin
        self_hit = 1'b0;
        on_body  = 1'b0;
        q_body   = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i + 1 < int'(len_q) || (grow && i + 1 == int'(len_q))) && i > 0 &&
                body_x[i] == nx && body_y[i] == ny)
                self_hit = 1'b1;
            if (i < int'(len_q) && body_x[i] == cand_x && body_y[i] == cand_y)
                on_body = 1'b1;
            if (i > 0 && i < int'(len_q) && body_x[i] == query_x && body_y[i] == query_y)
                q_body = 1'b1;
        end
        cand_ok = ({1'b0, cand_x} < X_OVER) && ({1'b0, cand_y} < Y_OVER) && !on_body;
        q_head  = (body_x[0] == query_x) && (body_y[0] == query_y);
        q_food  = (food_x == query_x) && (food_y == query_y);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            dir   <= D_RIGHT;
            pend  <= D_RIGHT;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_x[i] <= init_x(i);
                body_y[i] <= HOME_Y;
            end
            len_q    <= LW'(3);
            food_x   <= FOOD_X0;
            food_y   <= HOME_Y;
            lfsr     <= LFSR_SEED;
            cnt      <= '0;
            step_o   <= 1'b0;
            hit_head <= 1'b0;
            hit_body <= 1'b0;
            hit_food <= 1'b0;
        end else begin
            step_o   <= 1'b0;
            hit_head <= q_head;
            hit_body <= q_body;
            hit_food <= q_food;
            pend     <= next_pend;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state <= S_RUN;
                        dir   <= D_RIGHT;
                        pend  <= D_RIGHT;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            body_x[i] <= init_x(i);
                            body_y[i] <= HOME_Y;
                        end
                        len_q  <= LW'(3);
                        food_x <= FOOD_X0;
                        food_y <= HOME_Y;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (do_step) begin
                        cnt <= '0;
                        dir <= pend;
                        if (wall_hit || self_hit) begin
                            state <= S_OVER;
                        end else begin
                            step_o <= 1'b1;
                            for (int i = MAX_LEN - 1; i > 0; i--) begin
                                body_x[i] <= body_x[i-1];
                                body_y[i] <= body_y[i-1];
                            end
                            body_x[0] <= nx;
                            body_y[0] <= ny;
                            if (eat) state <= S_FOOD;
                            if (grow) len_q <= len_q + LW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FOOD: begin
                    lfsr <= lfsr_next;
                    if (cand_ok) begin
                        food_x <= cand_x;
                        food_y <= cand_y;
                        state  <= S_RUN;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_core.sv
// Bench for snake_core: directed game scenarios, then random play, all checked every
// cycle against a queue-based game model.
module tb_snake_core;
    localparam int GW = 8, GH = 8, ML = 8, SD = 4;
    localparam int XW = $clog2(GW), YW = $clog2(GH);

    logic       clk = 1'b0;
    logic       reset, up, down, left, right, start;
    logic [2:0] query_x, query_y;
    logic       hit_head, hit_body, hit_food, running, game_over, step_o;
    logic [3:0] length;

    int total = 0, passed = 0, failed = 0;

    // Game model: body as coordinate queues (head first); 0=IDLE 1=RUN 2=FOOD 3=OVER.
    int bx[$], by[$];
    int m_st, m_dir, m_pend, m_cnt, fx, fy, m_lfsr;
    int e_step, e_hh, e_hb, e_hf;
    int dxt[4] = '{0, 0, -1, 1};
    int dyt[4] = '{-1, 1, 0, 0};
    int opp[4] = '{1, 0, 3, 2};

    snake_core #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .STEP_DIV(SD)) dut (
        .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
        .start(start), .query_x(query_x), .query_y(query_y), .hit_head(hit_head),
        .hit_body(hit_body), .hit_food(hit_food), .length(length), .running(running),
        .game_over(game_over), .step_o(step_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_home();
        bx.delete();
        by.delete();
        for (int i = 0; i < 3; i++) begin
            bx.push_back(GW / 2 - i);
            by.push_back(GH / 2);
        end
        m_dir = 3;
        m_pend = 3;
        m_cnt = 0;
        fx = GW - 2;
        fy = GH / 2;
    endtask

    task automatic model_reset();
        model_home();
        m_st = 0;
        m_lfsr = 16'hACE1;
        e_step = 0; e_hh = 0; e_hb = 0; e_hf = 0;
    endtask

    task automatic model_edge();
        int nx, ny, bdir, rdir, new_pend, cx, cy, fb;
        bit do_step, wall, eat, grow, hit, ok;
        e_hh = (query_x == bx[0] && query_y == by[0]);
        e_hb = 0;
        for (int i = 1; i < bx.size(); i++)
            if (query_x == bx[i] && query_y == by[i]) e_hb = 1;
        e_hf = (query_x == fx && query_y == fy);
        e_step = 0;
        do_step = (m_st == 1 && m_cnt == SD - 1);
        rdir = do_step ? m_pend : m_dir;
        bdir = up ? 0 : down ? 1 : left ? 2 : right ? 3 : -1;
        new_pend = (bdir >= 0 && bdir != opp[rdir]) ? bdir : m_pend;
        case (m_st)
            0, 3: if (start) begin
                model_home();
                new_pend = 3;
                m_st = 1;
            end
            1: if (do_step) begin
                m_cnt = 0;
                m_dir = m_pend;
                nx = bx[0] + dxt[m_dir];
                ny = by[0] + dyt[m_dir];
`ifdef SNAKE_WRAP_EN
                nx = (nx + GW) % GW;
                ny = (ny + GH) % GH;
                wall = 0;
`else
                wall = (nx < 0 || nx >= GW || ny < 0 || ny >= GH);
`endif
                eat = (nx == fx && ny == fy);
                grow = eat && bx.size() < ML;
                hit = wall;
                for (int i = 1; i < bx.size(); i++)
                    if ((i <= bx.size() - 2 || (grow && i == bx.size() - 1)) &&
                        bx[i] == nx && by[i] == ny) hit = 1;
                if (hit) m_st = 3;
                else begin
                    e_step = 1;
                    bx.push_front(nx);
                    by.push_front(ny);
                    if (!grow) begin
                        void'(bx.pop_back());
                        void'(by.pop_back());
                    end
                    if (eat) m_st = 2;
                end
            end else m_cnt++;
            2: begin
                cx = m_lfsr % (1 << XW);
                cy = (m_lfsr >> XW) % (1 << YW);
                ok = (cx < GW && cy < GH);
                for (int i = 0; i < bx.size(); i++)
                    if (bx[i] == cx && by[i] == cy) ok = 0;
                fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
                m_lfsr = (m_lfsr >> 1) | (fb << 15);
                if (ok) begin
                    fx = cx;
                    fy = cy;
                    m_st = 1;
                end
            end
            default: ;
        endcase
        m_pend = new_pend;
    endtask

    task automatic compare_all();
        chk("step_o", step_o, e_step);
        chk("length", length, bx.size());
        chk("running", running, (m_st == 1 || m_st == 2));
        chk("game_over", game_over, (m_st == 3));
        chk("hit_head", hit_head, e_hh);
        chk("hit_body", hit_body, e_hb);
        chk("hit_food", hit_food, e_hf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_event(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(step_o === 1'b1 || game_over === 1'b1) && n < budget);
        chk("event_seen", (step_o === 1'b1 || game_over === 1'b1), 1);
    endtask

    task automatic query_check(input int x, input int y, input string tag);
        query_x = 3'(x);
        query_y = 3'(y);
        tick();
        chk(tag, hit_head, 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_length", length, 3);
        chk("rst_running", running, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_step", step_o, 0);
        chk("rst_hits", {hit_head, hit_body, hit_food}, 0);
        compare_all();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int n, r, hx, hy;
        reset = 1'b1;
        {up, down, left, right, start} = '0;
        query_x = '0;
        query_y = '0;
        model_reset();
        #3;
        chk("rst_length", length, 3);
        chk("rst_flags", {running, game_over, step_o}, 0);
        chk("rst_hits", {hit_head, hit_body, hit_food}, 0);
        compare_all();
        #9;
        reset = 1'b0;

        query_check(4, 4, "idle_head_4_4");
        query_x = 6; query_y = 4;
        tick();
        chk("idle_food_6_4", hit_food, 1);
        query_x = 3; query_y = 4;
        tick();
        chk("idle_body_3_4", hit_body, 1);

        // Game 1: left is the reverse of right and must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        left = 1'b1;
        wait_event(20, n);
        chk("first_step_period", n, 4);
        left = 1'b0;
        query_check(5, 4, "head_5_4");
        wait_event(20, n);
        chk("second_step_period", n, 3);
        chk("len_after_eat", length, 4);
        wait_event(20, n);
        chk("step_pause_in_food", n, 5);
        query_check(7, 4, "head_7_4");
        query_x = 1; query_y = 4;
        tick();
        chk("food_placed_1_4", hit_food, 1);
        wait_event(20, n);
`ifdef SNAKE_WRAP_EN
        chk("wrap_no_over", game_over, 0);
        query_check(0, 4, "wrap_head_0_4");
        apply_reset();
`else
        chk("wall_over", game_over, 1);
        chk("wall_len_frozen", length, 4);
        query_check(7, 4, "wall_head_stays");
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_running", running, 1);
        chk("restart_length", length, 3);
        query_check(4, 4, "restart_head_4_4");

        // Game 2: eat, then up/left/down so the head moves onto the vacating tail cell.
        wait_event(20, n);
        wait_event(20, n);
        chk("g2_len", length, 4);
        up = 1'b1;
        wait_event(20, n);
        up = 1'b0;
        left = 1'b1;
        query_check(6, 3, "up_head_6_3");
        wait_event(20, n);
        left = 1'b0;
        down = 1'b1;
        wait_event(20, n);
        down = 1'b0;
        chk("tail_no_over", game_over, 0);
        chk("tail_step", step_o, 1);
        query_check(5, 4, "tail_head_5_4");
        apply_reset();

        // Random play: food-seeking or random single buttons, random queries and starts.
        for (int c = 0; c < 2500; c++) begin
            {up, down, left, right} = '0;
            r = $urandom_range(0, 9);
            hx = bx[0];
            hy = by[0];
            if (r < 4) begin
                if (fx > hx) right = 1'b1;
                else if (fx < hx) left = 1'b1;
                else if (fy < hy) up = 1'b1;
                else down = 1'b1;
            end else if (r < 7) begin
                case ($urandom_range(0, 3))
                    0: up = 1'b1;
                    1: down = 1'b1;
                    2: left = 1'b1;
                    default: right = 1'b1;
                endcase
            end
            start = (m_st == 1 || m_st == 2) ? ($urandom_range(0, 40) == 0)
                                              : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                query_x = 3'(hx);
                query_y = 3'(hy);
            end else begin
                query_x = 3'($urandom_range(0, GW - 1));
                query_y = 3'($urandom_range(0, GH - 1));
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/snake_core.md
SNAKE_CORE -- requirements
Module: snake_core

Interface
REQ-001 SHALL have parameters: GRID_W, default 16, grid columns (4..64); GRID_H, default 12, grid rows (4..64); MAX_LEN, default 16, maximum body segments (3..64); STEP_DIV, default 6250000, clocks per move (>=2).
REQ-002 SHALL derive XW=$clog2(GRID_W), YW=$clog2(GRID_H), LW=$clog2(MAX_LEN+1).
REQ-003 SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- up, down, left, right  in  1 each  direction buttons, level, synchronous to clk.
- start  in  1  level; starts or restarts a game.
- query_x  in  XW  renderer cell column.
- query_y  in  YW  renderer cell row.
- hit_head  out  1  queried cell is head.
- hit_body  out  1  queried cell is a non-head segment.
- hit_food  out  1  queried cell is food.
- length  out  LW  current segment count.
- running  out  1  state is RUN or FOOD.
- game_over  out  1  state is OVER.
- step_o  out  1  one-cycle pulse on each executed move.

Function
REQ-004 SHALL implement states IDLE, RUN, FOOD, OVER; IDLE->RUN on start; RUN->FOOD on food eaten; FOOD->RUN on food placed; RUN->OVER on collision; OVER->RUN on start, reinitialising body, length, direction and food.
REQ-005 SHALL store segments in a MAX_LEN-entry coordinate shift buffer; entry 0 is head; entries >= length are ignored.
REQ-006 SHALL latch a pending direction every cycle from the buttons, priority up>down>left>right; none pressed keeps it; the reverse of the committed direction is ignored.
REQ-007 SHALL run a step counter 0..STEP_DIV-1 only in RUN; at terminal count it wraps to 0, commits the pending direction, executes one move and pulses step_o.
REQ-008 SHALL compute next head as head +/-1 in x or y; up decrements y.
REQ-009 SHALL treat a next head outside 0..GRID_W-1 / 0..GRID_H-1 as collision (see REQ-019).
REQ-010 SHALL treat a next head equal to any segment 1..length-2 as collision; the tail cell (length-1) is free unless growing on this move.
REQ-011 On collision, SHALL enter OVER without moving; body, length, food frozen.
REQ-012 On a legal move, SHALL shift the buffer by one and write the next head to entry 0.
REQ-013 If next head equals food, SHALL increment length saturating at MAX_LEN (saturated: move without growth) and enter FOOD.
REQ-014 In FOOD, SHALL advance a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) once per cycle; candidate x=lfsr[XW-1:0], y=lfsr[XW+YW-1:XW]; accept if in range and not on any active segment; the step counter is held.
REQ-015 SHALL register hit_head/hit_body/hit_food from query_x/query_y with exactly one cycle latency, valid in every state.
REQ-016 Simultaneous start and terminal count in RUN: start ignored.

Reset
REQ-017 On reset: state IDLE; head (GRID_W/2,GRID_H/2); segments 1,2 at x-1, x-2, same row; length 3; direction right; food (GRID_W-2,GRID_H/2); LFSR 16'hACE1; step counter 0; step_o, running, game_over, hit_* all 0.
REQ-018 Reset asserted mid-game SHALL restore REQ-017 values immediately, independent of clk.

Configuration
REQ-019 Macro SNAKE_WRAP_EN: defined -> out-of-range next head wraps modulo GRID_W/GRID_H (x -1 -> GRID_W-1, GRID_W -> 0; same for y) and is not a collision; undefined -> REQ-009 applies.

Verification
Parameters GRID_W=8, GRID_H=8, MAX_LEN=8, STEP_DIV=4 unless stated.
REQ-020 Reset, start pulse, no buttons -> step_o every 4 clocks; head (5,4) then (6,4); second move eats food, length 4, FOOD entered, step_o pauses until food placed off-body.
REQ-021 Direction right, press left only -> ignored, head x increments; press up -> next move head y decrements by 1.
REQ-022 Without SNAKE_WRAP_EN, head (7,4) moving right -> game_over=1 at that step, head stays (7,4); start -> running=1, head (4,4), length 3.
REQ-023 With SNAKE_WRAP_EN, head (7,4) moving right -> head (0,4), game_over=0.
REQ-024 Length 5, turns up,left,down in successive steps -> head enters segment 3 -> game_over=1; length 4 same path onto tail cell -> no collision.
REQ-025 query_x=4, query_y=4 after reset -> hit_head=1 next cycle; (6,4) -> hit_food=1; reset asserted mid-RUN -> all outputs at REQ-017 values before next clk edge.
